// File: rtl/fpu_issue_ctrl.sv
// FP coprocessor issue controller: reads FPR operands, holds them on the
// FPU inputs for FPU_LATENCY cycles, then writes back result, cc and flags.
module fpu_issue_ctrl #(
   parameter int FPU_LATENCY = 2,
   parameter int NUM_FPR     = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [4:0]  req_fs,
   input  logic [4:0]  req_ft,
   input  logic [4:0]  req_fd,
   output logic [31:0] fpu_a,
   output logic [31:0] fpu_b,
   output logic [3:0]  fpu_op,
   input  logic [31:0] fpu_result,
   input  logic        fpu_cc,
   input  logic        fpu_invalid,
   input  logic        fpu_overflow,
   input  logic        fpu_underflow,
   input  logic        wr_en,
   input  logic [4:0]  wr_addr,
   input  logic [31:0] wr_data,
   input  logic [4:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic        done,
   output logic        fp_cc_reg,
   output logic [2:0]  flags_sticky,
   input  logic        flag_clr
);
   localparam int CW = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_fpr [NUM_FPR];
   logic [3:0]    r_op;
   logic [4:0]    r_fd;
   logic [31:0]   r_res;
   logic          r_cc;
   logic [2:0]    r_flags;
   logic          w_accept;
   logic          w_wb;
   logic          w_wr_fpr;
   logic          w_wr_cc;
   logic          w_cnt_zero;
   logic [31:0]   w_opa;
   logic [31:0]   w_opb;

   always_comb begin
      w_next     = r_state;
      req_ready  = (r_state != S_EXEC);
      w_accept   = req_valid & req_ready;
      w_wb       = (r_state == S_WB);
      w_cnt_zero = (r_cnt == '0);
      w_wr_fpr   = w_wb & ((r_op == 4'd1) | (r_op == 4'd2) | (r_op == 4'd6));
      w_wr_cc    = w_wb & ((r_op == 4'd3) | (r_op == 4'd4) | (r_op == 4'd5));
      done       = w_wb & ~rst;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_EXEC;
         S_EXEC:  if (w_cnt_zero) w_next = S_WB;
         S_WB:    w_next = w_accept ? S_EXEC : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Back-to-back issue: forward the result being written this cycle
   always_comb begin
      w_opa = r_fpr[req_fs];
      w_opb = r_fpr[req_ft];
      if (w_wr_fpr && (r_fd == req_fs)) w_opa = r_res;
      if (w_wr_fpr && (r_fd == req_ft)) w_opb = r_res;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fpu_a  <= '0;
         fpu_b  <= '0;
         fpu_op <= '0;
         r_op   <= '0;
         r_fd   <= '0;
         r_cnt  <= '0;
      end else if (w_accept) begin
         fpu_a  <= w_opa;
         fpu_b  <= w_opb;
         fpu_op <= req_op;
         r_op   <= req_op;
         r_fd   <= req_fd;
         r_cnt  <= CW'(FPU_LATENCY - 1);
      end else if ((r_state == S_EXEC) && !w_cnt_zero) begin
         r_cnt  <= r_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_res   <= '0;
         r_cc    <= 1'b0;
         r_flags <= '0;
      end else if ((r_state == S_EXEC) && w_cnt_zero) begin
         r_res   <= fpu_result;
         r_cc    <= fpu_cc;
         r_flags <= {fpu_invalid, fpu_overflow, fpu_underflow};
      end
   end

   // Writeback is assigned last so it wins over a same-address external write
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_FPR; i++) r_fpr[i] <= '0;
      end else begin
         if (wr_en)    r_fpr[wr_addr] <= wr_data;
         if (w_wr_fpr) r_fpr[r_fd]    <= r_res;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fp_cc_reg    <= 1'b0;
         flags_sticky <= '0;
      end else begin
         if (w_wr_cc) fp_cc_reg <= r_cc;
         if (flag_clr)  flags_sticky <= w_wb ? r_flags : 3'b000;
         else if (w_wb) flags_sticky <= flags_sticky | r_flags;
      end
   end

   assign rd_data = r_fpr[rd_addr];

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: behavioural FPU plus a transaction-level
// model of the FPR, fp_cc and sticky flags.
module tb_fpu_issue_ctrl;
   localparam int L = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_op = '0;
   logic [4:0]  req_fs = '0;
   logic [4:0]  req_ft = '0;
   logic [4:0]  req_fd = '0;
   logic [31:0] fpu_a;
   logic [31:0] fpu_b;
   logic [3:0]  fpu_op;
   logic [31:0] fpu_result;
   logic        fpu_cc;
   logic        fpu_invalid;
   logic        fpu_overflow;
   logic        fpu_underflow;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [4:0]  rd_addr = '0;
   logic [31:0] rd_data;
   logic        done;
   logic        fp_cc_reg;
   logic [2:0]  flags_sticky;
   logic        flag_clr = 1'b0;

   always #5 clk = ~clk;

   fpu_issue_ctrl #(.FPU_LATENCY(L), .NUM_FPR(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_fs(req_fs), .req_ft(req_ft), .req_fd(req_fd),
      .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
      .fpu_result(fpu_result), .fpu_cc(fpu_cc),
      .fpu_invalid(fpu_invalid), .fpu_overflow(fpu_overflow),
      .fpu_underflow(fpu_underflow),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .done(done), .fp_cc_reg(fp_cc_reg),
      .flags_sticky(flags_sticky), .flag_clr(flag_clr)
   );

   function automatic real s2r(input logic [31:0] x);
      if (x[30:23] == 8'h00) return 0.0;
      return $bitstoreal({x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'b0});
   endfunction

   function automatic logic [31:0] r2s(input real r, output logic ov,
                                       output logic un);
      logic [63:0] b;
      int          ue;
      ov = 1'b0;
      un = 1'b0;
      b  = $realtobits(r);
      if (b[62:0] == 63'd0) return 32'h0;
      ue = int'(b[62:52]) - 896;
      if (ue >= 255) begin
         ov = 1'b1;
         return {b[63], 8'hFF, 23'd0};
      end
      if (ue <= 0) begin
         un = 1'b1;
         return {b[63], 31'd0};
      end
      return {b[63], 8'(ue), b[51:29]};
   endfunction

   // Behavioural FPU: {result, cc, invalid, overflow, underflow}
   function automatic logic [35:0] fpu_f(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      logic [31:0] res;
      logic        cc, inv, ov, un, nan_in;
      real         ra, rb;
      res = '0; cc = 0; inv = 0; ov = 0; un = 0;
      nan_in = (a[30:23] == 8'hFF) | (b[30:23] == 8'hFF);
      ra = s2r(a);
      rb = s2r(b);
      case (op)
         4'd1, 4'd2: begin
            if (nan_in) begin
               inv = 1'b1;
               res = 32'h7FC00000;
            end else begin
               res = r2s((op == 4'd1) ? ra + rb : ra - rb, ov, un);
            end
         end
         4'd3: if (nan_in) inv = 1'b1; else cc = (ra == rb);
         4'd4: if (nan_in) inv = 1'b1; else cc = (ra < rb);
         4'd5: if (nan_in) inv = 1'b1; else cc = (ra <= rb);
         4'd6: res = a;
         default: inv = 1'b1;
      endcase
      return {res, cc, inv, ov, un};
   endfunction

   assign {fpu_result, fpu_cc, fpu_invalid, fpu_overflow, fpu_underflow} =
      fpu_f(fpu_op, fpu_a, fpu_b);

   int          vec  = 0;
   int          errs = 0;
   logic [31:0] m_fpr [32];
   logic        m_cc;
   logic [2:0]  m_flags;
   logic [3:0]  p_op;
   logic [4:0]  p_fd;
   logic [31:0] p_a, p_b;
   logic        in_wb = 1'b0;
   logic        wb_w = 1'b0;
   logic [4:0]  wb_addr = '0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_fpr[i] = '0;
      m_cc    = 1'b0;
      m_flags = '0;
      in_wb   = 1'b0;
   endtask

   function automatic logic [31:0] rand_val();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 3))
         0: return {r[31], 8'($urandom_range(100, 150)), r[22:0]};
         1: return {r[31], 8'hFE, r[22:0]};
         2: return {1'b0, 8'($urandom_range(1, 2)), r[22:0]};
         default: return r;
      endcase
   endfunction

   task automatic check_rd(input logic [4:0] a);
      rd_addr = a;
      #1;
      vec++;
      if (rd_data !== m_fpr[a])
         $display("FAIL rd_data[%0d]: got %h want %h", a, rd_data, m_fpr[a]);
      if (rd_data !== m_fpr[a]) errs++;
   endtask

   task automatic check_all();
      for (int i = 0; i < 32; i++) check_rd(5'(i));
      tick();
   endtask

   // Cycles from the accept edge through the WB cycle
   task automatic exec_phase();
      for (int k = 0; k <= L; k++) begin
         vec++;
         if (done !== (k == L)) begin
            errs++;
            $display("FAIL done k=%0d: got %b want %b", k, done, k == L);
         end
         vec++;
         if (req_ready !== (k == L)) begin
            errs++;
            $display("FAIL req_ready k=%0d: got %b want %b", k, req_ready, k == L);
         end
         vec++;
         if ({fpu_op, fpu_a, fpu_b} !== {p_op, p_a, p_b}) begin
            errs++;
            $display("FAIL fpu_inputs k=%0d: got %h %h %h want %h %h %h",
                     k, fpu_op, fpu_a, fpu_b, p_op, p_a, p_b);
         end
         if (k < L) tick();
      end
   endtask

   task automatic accept(input logic [3:0] op, input logic [4:0] fd,
                         input logic [4:0] fs, input logic [4:0] ft,
                         input logic ext, input logic [4:0] ea,
                         input logic [31:0] ed, input logic run);
      req_valid = 1'b1;
      req_op = op; req_fd = fd; req_fs = fs; req_ft = ft;
      wr_en = ext; wr_addr = ea; wr_data = ed;
      vec++;
      if (req_ready !== 1'b1) begin
         errs++;
         $display("FAIL accept_ready: got %b want 1", req_ready);
      end
      p_op = op; p_fd = fd;
      p_a = m_fpr[fs];
      p_b = m_fpr[ft];
      if (ext && !(in_wb && wb_w && ea == wb_addr)) m_fpr[ea] = ed;
      tick();
      req_valid = 1'b0;
      wr_en = 1'b0;
      flag_clr = 1'b0;
      in_wb = 1'b0;
      if (run) exec_phase();
   endtask

   // Commit the op sitting in WB to the model (before any same-cycle accept)
   task automatic wb_commit(input logic clr);
      logic [35:0] r;
      flag_clr = clr;
      r = fpu_f(p_op, p_a, p_b);
      wb_w = (p_op == 4'd1) || (p_op == 4'd2) || (p_op == 4'd6);
      wb_addr = p_fd;
      if (wb_w) m_fpr[p_fd] = r[35:4];
      if (p_op >= 4'd3 && p_op <= 4'd5) m_cc = r[3];
      m_flags = (clr ? 3'b000 : m_flags) | r[2:0];
      in_wb = 1'b1;
   endtask

   task automatic idle_tick(input logic ext, input logic [4:0] ea,
                            input logic [31:0] ed, input logic clr);
      wr_en = ext; wr_addr = ea; wr_data = ed;
      if (!in_wb) flag_clr = clr;
      if (ext && !(in_wb && wb_w && ea == wb_addr)) m_fpr[ea] = ed;
      if (!in_wb && clr) m_flags = 3'b000;
      tick();
      wr_en = 1'b0;
      flag_clr = 1'b0;
      in_wb = 1'b0;
      vec++;
      if ({done, fp_cc_reg, flags_sticky} !== {1'b0, m_cc, m_flags}) begin
         errs++;
         $display("FAIL arch_state: got done=%b cc=%b fl=%b want 0 %b %b",
                  done, fp_cc_reg, flags_sticky, m_cc, m_flags);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      model_reset();
      vec++;
      if ({req_ready, done, fpu_op, fp_cc_reg, flags_sticky} !== 10'b1_0_0000_0_000) begin
         errs++;
         $display("FAIL reset_ctrl: got rdy=%b done=%b op=%h cc=%b fl=%b want 1 0 0 0 0",
                  req_ready, done, fpu_op, fp_cc_reg, flags_sticky);
      end
      vec++;
      if ({fpu_a, fpu_b} !== 64'd0) begin
         errs++;
         $display("FAIL reset_operands: got %h %h want 0 0", fpu_a, fpu_b);
      end
      check_all();
   endtask

   task automatic test_add();
      idle_tick(1'b1, 5'd1, 32'h3F800000, 1'b0);
      idle_tick(1'b1, 5'd2, 32'h40000000, 1'b0);
      accept(4'd1, 5'd3, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b1);
      wb_commit(1'b0);
      idle_tick(1'b0, 5'd0, 32'd0, 1'b0);
      check_rd(5'd3);
      vec++;
      if (rd_data !== 32'h40400000) begin
         errs++;
         $display("FAIL add_result: got %h want 40400000", rd_data);
      end
   endtask

   task automatic test_compare();
      accept(4'd4, 5'd9, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b1);
      wb_commit(1'b0);
      idle_tick(1'b0, 5'd0, 32'd0, 1'b0);
      vec++;
      if (fp_cc_reg !== 1'b1) begin
         errs++;
         $display("FAIL clt_cc: got %b want 1", fp_cc_reg);
      end
      accept(4'd3, 5'd9, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b1);
      wb_commit(1'b0);
      idle_tick(1'b0, 5'd0, 32'd0, 1'b0);
      vec++;
      if (fp_cc_reg !== 1'b0) begin
         errs++;
         $display("FAIL ceq_cc: got %b want 0", fp_cc_reg);
      end
      check_all();
   endtask

   task automatic test_back_to_back();
      accept(4'd1, 5'd3, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b1);
      wb_commit(1'b0);
      accept(4'd2, 5'd4, 5'd3, 5'd1, 1'b0, 5'd0, 32'd0, 1'b0);
      vec++;
      if (fpu_a !== 32'h40400000) begin
         errs++;
         $display("FAIL bypass_a: got %h want 40400000", fpu_a);
      end
      exec_phase();
      wb_commit(1'b0);
      idle_tick(1'b0, 5'd0, 32'd0, 1'b0);
      check_rd(5'd4);
      vec++;
      if (rd_data !== 32'h40000000) begin
         errs++;
         $display("FAIL sub_result: got %h want 40000000", rd_data);
      end
   endtask

   task automatic test_flags();
      idle_tick(1'b1, 5'd5, 32'h7F7FFFFF, 1'b0);
      idle_tick(1'b1, 5'd6, 32'h7F7FFFFF, 1'b0);
      accept(4'd1, 5'd7, 5'd5, 5'd6, 1'b0, 5'd0, 32'd0, 1'b1);
      wb_commit(1'b0);
      idle_tick(1'b0, 5'd0, 32'd0, 1'b0);
      vec++;
      if (flags_sticky !== 3'b010) begin
         errs++;
         $display("FAIL overflow_flag: got %b want 010", flags_sticky);
      end
      idle_tick(1'b0, 5'd0, 32'd0, 1'b1);
      vec++;
      if (flags_sticky !== 3'b000) begin
         errs++;
         $display("FAIL flag_clr: got %b want 000", flags_sticky);
      end
      accept(4'd1, 5'd8, 5'd5, 5'd6, 1'b0, 5'd0, 32'd0, 1'b1);
      wb_commit(1'b1);
      idle_tick(1'b0, 5'd0, 32'd0, 1'b0);
      vec++;
      if (flags_sticky !== 3'b010) begin
         errs++;
         $display("FAIL clr_with_wb: got %b want 010", flags_sticky);
      end
   endtask

   task automatic test_bad_op();
      accept(4'd0, 5'd9, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b1);
      wb_commit(1'b0);
      idle_tick(1'b0, 5'd0, 32'd0, 1'b0);
      vec++;
      if (flags_sticky[2] !== 1'b1) begin
         errs++;
         $display("FAIL badop_invalid: got %b want 1", flags_sticky[2]);
      end
      check_all();
   endtask

   task automatic test_reset_mid();
      accept(4'd1, 5'd7, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b0);
      for (int k = 0; k < L; k++) begin
         if (k == L - 1) rst = 1'b1;
         vec++;
         if (done !== 1'b0) begin
            errs++;
            $display("FAIL midrst_done k=%0d: got %b want 0", k, done);
         end
         tick();
      end
      vec++;
      if (done !== 1'b0) begin
         errs++;
         $display("FAIL midrst_done_after: got %b want 0", done);
      end
      rst = 1'b0;
      model_reset();
      tick();
      vec++;
      if (req_ready !== 1'b1) begin
         errs++;
         $display("FAIL midrst_ready: got %b want 1", req_ready);
      end
      check_rd(5'd7);
      check_all();
   endtask

   task automatic test_random();
      logic [3:0] ops [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                               4'd6, 4'd1, 4'd2, 4'd0, 4'hF};
      for (int i = 0; i < 32; i++)
         idle_tick(1'b1, 5'(i), rand_val(), 1'b0);
      for (int n = 0; n < 60; n++) begin
         accept(ops[$urandom_range(0, 9)], 5'($urandom), 5'($urandom),
                5'($urandom), ($urandom_range(0, 3) == 0), 5'($urandom),
                rand_val(), 1'b1);
         wb_commit($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 1) == 0 && n != 59) continue;
         idle_tick(($urandom_range(0, 2) == 0), 5'($urandom), rand_val(),
                   1'b0);
         check_rd(p_fd);
      end
      check_all();
   endtask

   initial begin
      test_reset();
      test_add();
      test_compare();
      test_back_to_back();
      test_flags();
      test_bad_op();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- FP coprocessor front end that drives the combinational floating-point unit and consumes its outputs.
- Accepts FP instructions from the decoder over a valid/ready handshake and reads operands from an internal FP register file (FPR).
- Presents operands and opcode to the FPU and holds them stable for FPU_LATENCY cycles.
- Captures result, condition and exception flags, then writes back to the FPR, the fp_cc register and the sticky exception register.

Parameters:
- FPU_LATENCY, 2, cycles operands are held before capture (>=1).
- NUM_FPR, 32, FP register count (address width 5).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  instruction valid
- req_ready  out  1  controller can accept
- req_op  in  4  FPU opcode: 1 add.s, 2 sub.s, 3 c.eq.s, 4 c.lt.s, 5 c.le.s, 6 mov.s
- req_fs  in  5  source A register
- req_ft  in  5  source B register
- req_fd  in  5  destination register
- fpu_a  out  32  operand A to FPU
- fpu_b  out  32  operand B to FPU
- fpu_op  out  4  opcode to FPU
- fpu_result  in  32  FPU result
- fpu_cc  in  1  FPU compare flag
- fpu_invalid  in  1  FPU invalid flag
- fpu_overflow  in  1  FPU overflow flag
- fpu_underflow  in  1  FPU underflow flag
- wr_en  in  1  external FPR write (mtc1/lwc1)
- wr_addr  in  5  external write address
- wr_data  in  32  external write data
- rd_addr  in  5  debug/mfc1 read address
- rd_data  out  32  combinational FPR[rd_addr]
- done  out  1  one-cycle completion pulse
- fp_cc_reg  out  1  architectural FP condition bit
- flags_sticky  out  3  {invalid, overflow, underflow}, sticky
- flag_clr  in  1  clear sticky flags

Behaviour:
- Reset values: state IDLE; fpu_a, fpu_b, fpu_op, done, fp_cc_reg, flags_sticky all 0; every FPR entry 0; req_ready 1 once out of reset.
- FSM has three states: IDLE, EXEC, WB.
- req_ready = 1 in IDLE and WB, 0 in EXEC.
- Accept: req_valid & req_ready at an edge.
  - Registers fpu_a = FPR[fs], fpu_b = FPR[ft], fpu_op = req_op, latched fd/op.
  - Sets cnt = FPU_LATENCY-1 and moves to EXEC.
- EXEC:
  - fpu_a, fpu_b and fpu_op are held constant.
  - cnt != 0: decrement.
  - cnt == 0: capture fpu_result, fpu_cc and the three flags into holding registers, then go to WB.
- WB (exactly one cycle, done=1):
  - op 1/2/6: FPR[fd] <= captured result.
  - op 3/4/5: fp_cc_reg <= captured cc; no FPR write.
  - Any other op: no FPR write, fp_cc_reg unchanged.
  - flags_sticky <= flags_sticky | captured flags.
  - Next state is EXEC if a new request is accepted this cycle, else IDLE.
- Latency: done is high in the cycle after the accept edge + FPU_LATENCY edges. The result is readable on rd_data after the following edge. Throughput is one op per FPU_LATENCY+1 cycles.
- Bypass: on accept during WB, if a writing op's fd equals req_fs or req_ft, that operand takes the captured result instead of the stale FPR value.
- External write:
  - Applied at any edge where wr_en=1.
  - If WB writes the same address in the same cycle, the WB write wins and the external write is dropped.
  - Different addresses are both written.
  - On accept, an operand whose address matches an external write in the same cycle reads the old value; no forwarding from the external port.
- flag_clr:
  - Without WB: flags_sticky <= 0.
  - Same cycle as WB: flags_sticky <= captured flags (clear first, then set).
- Reset mid-operation (rst in EXEC or WB): abort, no FPR/cc/flag update, done 0, return to IDLE.
- Register 0 is an ordinary writable FP register.

Test Plan:
- FPR1=0x3F800000, FPR2=0x40000000 via wr_en; add.s fd=3 fs=1 ft=2, FPU_LATENCY=2 -> fpu_op=1 stable 2 cycles, done 2 cycles after accept edge, rd_data(3)=0x40400000.
- c.lt.s fs=1 ft=2 -> fp_cc_reg=1; then c.eq.s fs=1 ft=2 -> fp_cc_reg=0; FPR unchanged; req_ready low only during EXEC.
- add.s f3=f1+f2, then sub.s f4=f3-f1 with req_valid held -> sub accepted in the WB cycle, bypass gives fpu_a=0x40400000, FPR4=0x40000000.
- FPR5=FPR6=0x7F7FFFFF, add.s -> flags_sticky=3'b010; later flag_clr alone -> 3'b000; flag_clr coincident with WB of an overflowing add -> 3'b010.
- req_op=4'b0000 -> done pulses, flags_sticky[2]=1, no FPR write, fp_cc_reg unchanged.
- rst during EXEC of add.s fd=7 -> FPR7=0, done never pulses, all FPR 0, req_ready=1 the cycle after reset deasserts.
